// File: rtl/slink_apb_tgt_if.sv
// APB completer-side bus bundle for slink_apb_tgt.
//   master : drives address/control/write data, samples read data and handshake
//   slave  : the target side (slink_apb_tgt), returns prdata/pready/pslverr
interface slink_apb_tgt_if;
  logic [31:0] apb_paddr;
  logic        apb_pwrite;
  logic        apb_psel;
  logic        apb_penable;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic        apb_pslverr;

  modport master (
    output apb_paddr, apb_pwrite, apb_psel, apb_penable, apb_pwdata,
    input  apb_prdata, apb_pready, apb_pslverr
  );

  modport slave (
    input  apb_paddr, apb_pwrite, apb_psel, apb_penable, apb_pwdata,
    output apb_prdata, apb_pready, apb_pslverr
  );
endinterface

// File: rtl/slink_apb_tgt.sv
// APB target that tunnels each APB access over a packet link.
// An access is turned into one request packet (a2l_*), the block then waits for the matching
// response packet (l2a_*) and completes the APB transfer with its data/error, or with an error
// on timeout or when the link is disabled.
//
// Ports:
//   apb_clk, apb_reset   clock, asynchronous active-high reset
//   apb                  APB completer (paddr/pwrite/psel/penable/pwdata in, prdata/pready/pslverr out)
//   enable               asynchronous link enable, synchronized internally
//   a2l_data/valid/ready request packet out: [7:0] DT, [23:8] WC, [55:24] addr, [87:56] wdata
//   l2a_data/valid       response packet in: [7:0] DT, [55:24] rdata, [56] rd err, [24] wr err
//   l2a_accept           response consumed this cycle
//   invalid_resp_pkt     one-cycle pulse: unexpected DT while waiting
//   stale_resp_pkt       one-cycle pulse: response dropped while no request outstanding
//   timeout              one-cycle pulse: no response within TIMEOUT_CYCLES
module slink_apb_tgt #(
  parameter logic [7:0]  APB_READ_DT      = 8'h24,
  parameter logic [7:0]  APB_READ_RSP_DT  = 8'h25,
  parameter logic [7:0]  APB_WRITE_DT     = 8'h26,
  parameter logic [7:0]  APB_WRITE_RSP_DT = 8'h27,
  parameter int unsigned TIMEOUT_CYCLES   = 4096
) (
  input  logic                 apb_clk,
  input  logic                 apb_reset,
  slink_apb_tgt_if.slave       apb,
  input  logic                 enable,
  output logic [87:0]          a2l_data,
  output logic                 a2l_valid,
  input  logic                 a2l_ready,
  input  logic [56:0]          l2a_data,
  input  logic                 l2a_valid,
  output logic                 l2a_accept,
  output logic                 invalid_resp_pkt,
  output logic                 stale_resp_pkt,
  output logic                 timeout
);

  typedef enum logic [1:0] {StIdle, StSendReq, StWaitRsp, StComplete} state_e;

  state_e      state_q, state_d;
  logic [1:0]  en_sync_q;
  logic [87:0] pkt_q, pkt_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        slverr_q, slverr_d;
  logic        invalid_q, invalid_d;
  logic        stale_q, stale_d;
  logic        timeout_q, timeout_d;

  logic        enable_s;
  logic        access;
  logic [7:0]  rsp_dt_exp;
  logic        rsp_match;
  logic        timeout_hit;
  logic        unused_wc;

  assign enable_s    = en_sync_q[1];
  assign access      = apb.apb_psel & apb.apb_penable;
  assign rsp_dt_exp  = pwrite_q ? APB_WRITE_RSP_DT : APB_READ_RSP_DT;
  assign rsp_match   = l2a_valid && (l2a_data[7:0] == rsp_dt_exp);
  // cnt_q holds the number of WAIT cycles already spent, so this is the last allowed one
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);
  // Response word count carries no information for this target
  assign unused_wc   = ^l2a_data[23:8];

  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    pwrite_d   = pwrite_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    slverr_d   = slverr_q;
    invalid_d  = 1'b0;
    stale_d    = 1'b0;
    timeout_d  = 1'b0;
    a2l_valid  = 1'b0;
    l2a_accept = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Nothing outstanding: any response is a leftover and is drained
        l2a_accept = l2a_valid;
        stale_d    = l2a_valid;
        if (access) begin
          if (enable_s) begin
            pwrite_d = apb.apb_pwrite;
            cnt_d    = '0;
            pkt_d    = apb.apb_pwrite ?
                       {apb.apb_pwdata, apb.apb_paddr, 16'd8, APB_WRITE_DT} :
                       {32'h0, apb.apb_paddr, 16'd4, APB_READ_DT};
            state_d  = StSendReq;
          end else begin
            rdata_d  = '0;
            slverr_d = 1'b1;
            state_d  = StComplete;
          end
        end
      end
      StSendReq: begin
        a2l_valid  = 1'b1;
        l2a_accept = l2a_valid;
        stale_d    = l2a_valid;
        if (a2l_ready) state_d = StWaitRsp;
      end
      StWaitRsp: begin
        cnt_d      = cnt_q + 32'd1;
        l2a_accept = l2a_valid;
        if (rsp_match) begin
          // A matching response beats a timeout landing in the same cycle
          rdata_d  = pwrite_q ? 32'h0 : l2a_data[55:24];
          slverr_d = pwrite_q ? l2a_data[24] : l2a_data[56];
          state_d  = StComplete;
        end else begin
          invalid_d = l2a_valid;
          if (timeout_hit) begin
            rdata_d   = '0;
            slverr_d  = 1'b1;
            timeout_d = 1'b1;
            state_d   = StComplete;
          end
        end
      end
      StComplete: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge apb_clk or posedge apb_reset) begin
    if (apb_reset) begin
      state_q   <= StIdle;
      en_sync_q <= 2'b00;
      pkt_q     <= '0;
      pwrite_q  <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      invalid_q <= 1'b0;
      stale_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_sync_q <= {en_sync_q[0], enable};
      pkt_q     <= pkt_d;
      pwrite_q  <= pwrite_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      invalid_q <= invalid_d;
      stale_q   <= stale_d;
      timeout_q <= timeout_d;
    end
  end

  assign a2l_data         = pkt_q;
  assign apb.apb_pready   = (state_q == StComplete);
  assign apb.apb_prdata   = apb.apb_pready ? rdata_q : 32'h0;
  assign apb.apb_pslverr  = apb.apb_pready & slverr_q;
  assign invalid_resp_pkt = invalid_q;
  assign stale_resp_pkt   = stale_q;
  assign timeout          = timeout_q;

endmodule

// File: tb/tb_slink_apb_tgt.sv
module tb_slink_apb_tgt;
  localparam int unsigned TO     = 16;
  localparam logic [7:0]  RD_DT  = 8'h24;
  localparam logic [7:0]  RD_RSP = 8'h25;
  localparam logic [7:0]  WR_DT  = 8'h26;
  localparam logic [7:0]  WR_RSP = 8'h27;

  logic        apb_clk   = 1'b0;
  logic        apb_reset = 1'b1;
  logic        enable    = 1'b0;
  logic        a2l_ready = 1'b0;
  logic        l2a_valid = 1'b0;
  logic [56:0] l2a_data  = '0;
  logic [87:0] a2l_data;
  logic        a2l_valid;
  logic        l2a_accept;
  logic        invalid_resp_pkt;
  logic        stale_resp_pkt;
  logic        timeout;

  slink_apb_tgt_if apb ();

  slink_apb_tgt #(
    .APB_READ_DT     (RD_DT),
    .APB_READ_RSP_DT (RD_RSP),
    .APB_WRITE_DT    (WR_DT),
    .APB_WRITE_RSP_DT(WR_RSP),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .apb_clk         (apb_clk),
    .apb_reset       (apb_reset),
    .apb             (apb),
    .enable          (enable),
    .a2l_data        (a2l_data),
    .a2l_valid       (a2l_valid),
    .a2l_ready       (a2l_ready),
    .l2a_data        (l2a_data),
    .l2a_valid       (l2a_valid),
    .l2a_accept      (l2a_accept),
    .invalid_resp_pkt(invalid_resp_pkt),
    .stale_resp_pkt  (stale_resp_pkt),
    .timeout         (timeout)
  );

  always #5 apb_clk = ~apb_clk;

  int tests = 0;
  int fails = 0;
  int inv_seen = 0, stale_seen = 0, to_seen = 0;
  int inv_exp = 0, stale_exp = 0, to_exp = 0;
  bit toggle_en = 1'b0;

  // Expected request packets and expected APB completions {prdata, pslverr}
  logic [87:0] exp_pkt[$];
  logic [32:0] exp_cpl[$];
  logic [32:0] mon_cpl;
  logic [31:0] last_prdata = '0;
  logic        last_pslverr = 1'b0;
  logic [87:0] first_pkt = '0;
  bit          first_pkt_seen = 1'b0;

  task automatic report(input string name, input logic [87:0] act, input logic [87:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    report(name, {87'd0, act}, {87'd0, exp});
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    report(name, {56'd0, act}, {56'd0, exp});
  endtask

  task automatic chk88(input string name, input logic [87:0] act, input logic [87:0] exp);
    report(name, act, exp);
  endtask

  // Request packet as the link expects it
  function automatic logic [87:0] req_pkt(input bit wr, input logic [31:0] addr,
                                          input logic [31:0] wdata);
    if (wr) return {wdata, addr, 16'd8, WR_DT};
    return {32'd0, addr, 16'd4, RD_DT};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk1({tag, " a2l_valid"}, a2l_valid, 1'b0);
    chk88({tag, " a2l_data"}, a2l_data, 88'd0);
    chk1({tag, " l2a_accept"}, l2a_accept, 1'b0);
    chk1({tag, " pready"}, apb.apb_pready, 1'b0);
    chk32({tag, " prdata"}, apb.apb_prdata, 32'd0);
    chk1({tag, " pslverr"}, apb.apb_pslverr, 1'b0);
    chk1({tag, " invalid_resp_pkt"}, invalid_resp_pkt, 1'b0);
    chk1({tag, " stale_resp_pkt"}, stale_resp_pkt, 1'b0);
    chk1({tag, " timeout"}, timeout, 1'b0);
  endtask

  // Per-cycle compare against the expected packet/completion queues
  always @(negedge apb_clk) begin
    if (!apb_reset) begin
      if (a2l_valid) begin
        if (exp_pkt.size() == 0) begin
          chk1("a2l_valid without request", a2l_valid, 1'b0);
        end else begin
          if (!first_pkt_seen) begin
            first_pkt      = a2l_data;
            first_pkt_seen = 1'b1;
          end
          chk88("a2l_data", a2l_data, exp_pkt[0]);
          if (a2l_ready) void'(exp_pkt.pop_front());
        end
      end
      if (apb.apb_pready) begin
        last_prdata  = apb.apb_prdata;
        last_pslverr = apb.apb_pslverr;
        if (exp_cpl.size() == 0) begin
          chk1("pready without transfer", apb.apb_pready, 1'b0);
        end else begin
          mon_cpl = exp_cpl.pop_front();
          chk32("prdata", apb.apb_prdata, mon_cpl[32:1]);
          chk1("pslverr", apb.apb_pslverr, mon_cpl[0]);
        end
      end else begin
        chk32("prdata while not ready", apb.apb_prdata, 32'd0);
        chk1("pslverr while not ready", apb.apb_pslverr, 1'b0);
      end
      if (invalid_resp_pkt) inv_seen++;
      if (stale_resp_pkt) stale_seen++;
      if (timeout) to_seen++;
    end
  end

  // One APB transfer. rsp_at: WAIT cycle index of the good response, -1 = never (timeout).
  // ninv: invalid responses in WAIT cycles 0..ninv-1. rst_at: WAIT cycle to reset in, -1 = none.
  // late: present a response after the transfer ends (must be dropped as stale).
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit en, input int settle, input int rdly, input int ninv,
                     input int rsp_at, input logic [31:0] rdata, input bit serr,
                     input bit late, input int rst_at);
    bit          eff_en;
    bit          aborted;
    logic [7:0]  good_dt;
    logic [56:0] rsp;
    logic [32:0] cpl;
    int          last_w;
    aborted = 1'b0;
    good_dt = wr ? WR_RSP : RD_RSP;
    @(posedge apb_clk);
    #1;
    // Enable reaches the FSM two edges after it changes
    eff_en = (settle >= 1) ? en : enable;
    enable = en;
    if (settle > 0) begin
      repeat (settle) @(posedge apb_clk);
      #1;
    end
    apb.apb_psel    = 1'b1;
    apb.apb_pwrite  = wr;
    apb.apb_paddr   = addr;
    apb.apb_pwdata  = wdata;
    apb.apb_penable = 1'b0;
    @(posedge apb_clk);
    #1;
    apb.apb_penable = 1'b1;
    if (eff_en) exp_pkt.push_back(req_pkt(wr, addr, wdata));
    else exp_cpl.push_back({32'd0, 1'b1});
    @(posedge apb_clk);
    #1;
    if (!eff_en) begin
      @(negedge apb_clk);
      chk1("disabled pready latency", apb.apb_pready, 1'b1);
      chk1("disabled no a2l_valid", a2l_valid, 1'b0);
      @(posedge apb_clk);
      #1;
      apb.apb_psel    = 1'b0;
      apb.apb_penable = 1'b0;
      @(negedge apb_clk);
      chk1("pready one cycle", apb.apb_pready, 1'b0);
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        a2l_ready = (i == rdly);
        l2a_valid = (i < rdly) && ($urandom_range(0, 2) == 0);
        l2a_data  = 57'({$urandom(), $urandom()});
        if (l2a_valid) stale_exp++;
        @(negedge apb_clk);
        chk1("a2l_valid while sending", a2l_valid, 1'b1);
        if (l2a_valid) chk1("stale accept while sending", l2a_accept, 1'b1);
        @(posedge apb_clk);
        #1;
      end
      a2l_ready = 1'b0;
      l2a_valid = 1'b0;
      if (toggle_en) enable = 1'($urandom_range(0, 1));
      cpl = (rsp_at < 0) ? {32'd0, 1'b1} : (wr ? {32'd0, serr} : {rdata, serr});
      if (rst_at < 0) exp_cpl.push_back(cpl);
      last_w = (rsp_at < 0) ? int'(TO) - 1 : rsp_at;
      for (int w = 0; w <= last_w; w++) begin
        if (w == rst_at) begin
          apb_reset       = 1'b1;
          apb.apb_psel    = 1'b0;
          apb.apb_penable = 1'b0;
          @(negedge apb_clk);
          chk_all_zero("reset in wait");
          exp_pkt.delete();
          exp_cpl.delete();
          @(posedge apb_clk);
          #1;
          apb_reset = 1'b0;
          aborted   = 1'b1;
          break;
        end
        rsp = 57'({$urandom(), $urandom()});
        if (w == rsp_at) begin
          rsp[7:0] = good_dt;
          if (wr) rsp[24] = serr;
          else begin
            rsp[55:24] = rdata;
            rsp[56]    = serr;
          end
          l2a_valid = 1'b1;
        end else if (w < ninv) begin
          rsp[7:0]  = good_dt ^ ((w == 0) ? 8'h02 : 8'($urandom_range(1, 255)));
          l2a_valid = 1'b1;
          inv_exp++;
        end
        l2a_data = rsp;
        @(negedge apb_clk);
        chk1("pready during wait", apb.apb_pready, 1'b0);
        chk1("a2l_valid during wait", a2l_valid, 1'b0);
        if (l2a_valid) chk1("l2a_accept during wait", l2a_accept, 1'b1);
        @(posedge apb_clk);
        #1;
        l2a_valid = 1'b0;
      end
      if (!aborted) begin
        if (rsp_at < 0) to_exp++;
        @(negedge apb_clk);
        chk1("completion latency", apb.apb_pready, 1'b1);
        @(posedge apb_clk);
        #1;
        apb.apb_psel    = 1'b0;
        apb.apb_penable = 1'b0;
      end
      if (late) begin
        rsp       = 57'({$urandom(), $urandom()});
        rsp[7:0]  = good_dt;
        l2a_data  = rsp;
        l2a_valid = 1'b1;
        stale_exp++;
        @(negedge apb_clk);
        chk1("late response accepted", l2a_accept, 1'b1);
        @(posedge apb_clk);
        #1;
        l2a_valid = 1'b0;
      end
      @(negedge apb_clk);
      chk1("pready back low", apb.apb_pready, 1'b0);
    end
    repeat (2) @(posedge apb_clk);
    chk32("invalid_resp_pkt pulse count", inv_seen, inv_exp);
    chk32("stale_resp_pkt pulse count", stale_seen, stale_exp);
    chk32("timeout pulse count", to_seen, to_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 expected end");
    $fatal(1);
  end

  initial begin
    apb.apb_psel    = 1'b0;
    apb.apb_penable = 1'b0;
    apb.apb_pwrite  = 1'b0;
    apb.apb_paddr   = '0;
    apb.apb_pwdata  = '0;
    repeat (2) @(negedge apb_clk);
    chk_all_zero("reset");
    @(posedge apb_clk);
    #1;
    apb_reset = 1'b0;

    // Write with prompt response
    first_pkt_seen = 1'b0;
    txn(1'b1, 32'h1000, 32'hDEADBEEF, 1'b1, 3, 0, 0, 5, 32'h0, 1'b0, 1'b0, -1);
    chk88("write packet", first_pkt, 88'hDEADBEEF_00001000_0008_26);
    chk1("write pslverr", last_pslverr, 1'b0);

    // Read with back-pressure and error response
    first_pkt_seen = 1'b0;
    txn(1'b0, 32'h20, 32'h0, 1'b1, 3, 3, 0, 2, 32'hCAFEF00D, 1'b1, 1'b0, -1);
    chk88("read packet", first_pkt, 88'h00000000_00000020_0004_24);
    chk32("read prdata", last_prdata, 32'hCAFEF00D);
    chk1("read pslverr", last_pslverr, 1'b1);

    // Wrong DT first, then the real response
    txn(1'b0, 32'h44, 32'h0, 1'b1, 3, 0, 1, 1, 32'h12345678, 1'b0, 1'b0, -1);
    chk32("read after invalid prdata", last_prdata, 32'h12345678);

    // Timeout, then the late response arrives
    txn(1'b0, 32'h80, 32'h0, 1'b1, 3, 0, 0, -1, 32'h0, 1'b0, 1'b1, -1);
    chk32("timeout prdata", last_prdata, 32'h0);
    chk1("timeout pslverr", last_pslverr, 1'b1);

    // Response in the very cycle the timeout would fire
    txn(1'b1, 32'h84, 32'h55, 1'b1, 3, 1, 0, int'(TO) - 1, 32'h0, 1'b1, 1'b0, -1);
    chk1("boundary write pslverr", last_pslverr, 1'b1);

    // Disabled link, then synchronizer latency in both directions
    txn(1'b0, 32'h0, 32'h0, 1'b0, 3, 0, 0, 0, 32'h0, 1'b0, 1'b0, -1);
    txn(1'b1, 32'h10, 32'h1, 1'b1, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0, -1);
    txn(1'b0, 32'h14, 32'h0, 1'b0, 3, 0, 0, 0, 32'h0, 1'b0, 1'b0, -1);
    txn(1'b1, 32'h18, 32'h2, 1'b1, 1, 0, 0, 1, 32'h0, 1'b0, 1'b0, -1);
    txn(1'b0, 32'h1C, 32'h0, 1'b0, 0, 0, 0, 3, 32'hA5A5A5A5, 1'b0, 1'b0, -1);

    // Reset while waiting, late response afterwards
    txn(1'b0, 32'h90, 32'h0, 1'b1, 3, 0, 0, -1, 32'h0, 1'b0, 1'b1, 3);

    toggle_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int ra;
      int ni;
      ra = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      if (ra < 0) ni = int'($urandom_range(0, 3));
      else ni = int'($urandom_range(0, (ra < 2) ? ra : 2));
      txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), ($urandom_range(0, 4) != 0),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ni, ra, $urandom(),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), -1);
    end

    chk32("leftover expected packets", exp_pkt.size(), 32'd0);
    chk32("leftover expected completions", exp_cpl.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slink_apb_tgt.md
SLINK_APB_TGT -- requirements
Module: slink_apb_tgt

Interface
REQ-001 SHALL provide parameter APB_READ_DT, default 8'h24, data ID of outgoing read request packet.
REQ-002 SHALL provide parameter APB_READ_RSP_DT, default 8'h25, expected data ID of read response packet.
REQ-003 SHALL provide parameter APB_WRITE_DT, default 8'h26, data ID of outgoing write request packet.
REQ-004 SHALL provide parameter APB_WRITE_RSP_DT, default 8'h27, expected data ID of write response packet.
REQ-005 SHALL provide parameter TIMEOUT_CYCLES, default 4096, response wait limit in apb_clk cycles; 0 disables timeout.
REQ-006 SHALL have ports: apb_clk input 1, clock; apb_reset input 1, reset, asynchronous, active-high.
REQ-007 SHALL have ports: apb_paddr in 32, apb_pwrite in 1, apb_psel in 1, apb_penable in 1, apb_pwdata in 32 (APB completer side).
REQ-008 SHALL have ports: apb_prdata out 32, apb_pready out 1, apb_pslverr out 1.
REQ-009 SHALL have ports: enable in 1 (asynchronous), a2l_data out 88, a2l_valid out 1, a2l_ready in 1.
REQ-010 SHALL have ports: l2a_data in 57, l2a_valid in 1, l2a_accept out 1, invalid_resp_pkt out 1, stale_resp_pkt out 1, timeout out 1.

Function
REQ-011 SHALL synchronize enable into apb_clk with a 2-flop synchronizer (2-cycle latency).
REQ-012 SHALL format a2l_data as [7:0] DT, [23:8] WC, [55:24] PADDR, [87:56] PWDATA; read: DT=APB_READ_DT, WC=4, [87:56]=0; write: DT=APB_WRITE_DT, WC=8.
REQ-013 SHALL decode l2a_data as [7:0] DT, [23:8] WC (ignored), [55:24] read data, [56] slverr for read responses; [24] slverr for write responses.
REQ-014 SHALL implement states IDLE, SEND_REQ, WAIT_RSP, COMPLETE; all reset to IDLE.
REQ-015 IDLE: on psel&penable with synced enable=1, SHALL latch paddr/pwdata/pwrite, clear timeout counter, go SEND_REQ.
REQ-016 IDLE: on psel&penable with synced enable=0, SHALL go COMPLETE with pslverr=1, prdata=0, and no packet sent.
REQ-017 SEND_REQ: a2l_valid=1 with latched packet, data stable while a2l_ready=0; on a2l_ready=1 go WAIT_RSP next cycle.
REQ-018 WAIT_RSP: on l2a_valid with DT equal to expected response DT (per latched pwrite), SHALL assert l2a_accept that cycle, capture rdata (reads only, 0 for writes) and slverr, go COMPLETE.
REQ-019 WAIT_RSP: on l2a_valid with any other DT, SHALL assert l2a_accept, pulse invalid_resp_pkt one cycle, remain in WAIT_RSP.
REQ-020 WAIT_RSP: counter increments each cycle; on reaching TIMEOUT_CYCLES (nonzero) SHALL go COMPLETE with pslverr=1, prdata=0, pulse timeout one cycle.
REQ-021 Simultaneous valid matching response and timeout in the same cycle: response wins, no timeout pulse.
REQ-022 COMPLETE: apb_pready=1 for exactly one cycle with registered prdata/pslverr, then IDLE.
REQ-023 apb_pready SHALL be 0 in IDLE, SEND_REQ, WAIT_RSP; prdata/pslverr SHALL be 0 whenever pready=0.
REQ-024 IDLE (and SEND_REQ): any l2a_valid SHALL be accepted and dropped with a one-cycle stale_resp_pkt pulse (late response after timeout).
REQ-025 Minimum latency: access cycle N -> a2l_valid N+1; response accepted cycle M -> pready M+1.
REQ-026 Enable deasserting mid-transaction SHALL NOT abort; transaction completes via response or timeout.
REQ-027 Only one outstanding request; psel/penable during non-IDLE states are treated as the held current transfer.

Reset
REQ-028 On apb_reset: state IDLE, counter 0, latched fields 0, all outputs 0 (a2l_valid, a2l_data, l2a_accept, pready, prdata, pslverr, pulse flags), synchronizer flops 0.
REQ-029 Reset mid-transaction SHALL drop the pending request; subsequent late response handled per REQ-024.

Verification
REQ-030 Write 0x1000<-0xDEADBEEF, a2l_ready=1, response DT 0x27 slverr=0 after 5 cycles -> a2l_data={0xDEADBEEF,0x00001000,16'd8,8'h26}, pready=1 one cycle, pslverr=0.
REQ-031 Read 0x20, a2l_ready low 3 cycles, response DT 0x25 data 0xCAFEF00D slverr=1 -> a2l_data stable 4 cycles, prdata=0xCAFEF00D, pslverr=1.
REQ-032 Read with response DT 0x27 then 0x25 -> invalid_resp_pkt pulse once, both accepted, completion on second with read data.
REQ-033 TIMEOUT_CYCLES=16, no response -> timeout pulse, pready with pslverr=1 prdata=0; later response DT 0x25 -> stale_resp_pkt pulse, accepted.
REQ-034 enable=0, access to 0x0 -> no a2l_valid, pready next cycle with pslverr=1; assert apb_reset during WAIT_RSP -> all outputs 0, state IDLE.
